// File: rtl/multicycle_ctrl_if.sv
// Control/datapath boundary of the THCO-MIPS16 multicycle controller.
// The master modport is the controller; the slave modport is the datapath and memory side.
interface multicycle_ctrl_if;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        alu_zero;
    logic [15:0] ir;
    logic [7:0]  ALU_Src2;
    logic [1:0]  alu_src1;
    logic        alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic        wb_src;
    logic        illegal;

    modport master (
        input  mem_data, mem_ready, alu_zero,
        output ir, ALU_Src2, alu_src1, alu_op, mem_rd, mem_wr,
               pc_write, pc_src, reg_write, wb_src, illegal
    );

    modport slave (
        output mem_data, mem_ready, alu_zero,
        input  ir, ALU_Src2, alu_src1, alu_op, mem_rd, mem_wr,
               pc_write, pc_src, reg_write, wb_src, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EXE/MEM/WB control FSM for the 16-bit THCO-MIPS16 datapath.
// Holds the instruction register and drives the ALU operand selects and datapath strobes.
module multicycle_ctrl #(
    parameter logic [7:0] RY     = 8'h06,
    parameter logic [7:0] ZERO   = 8'h10,
    parameter logic [7:0] S_IMM4 = 8'h14,
    parameter logic [7:0] S_IMM5 = 8'h15,
    parameter logic [7:0] S_IMM8 = 8'h16,
    parameter logic [7:0] ONE    = 8'h26
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [2:0] {ST_IF, ST_ID, ST_EXE, ST_MEM, ST_WB} state_t;

    localparam logic [4:0] OP_NOP    = 5'b00001;
    localparam logic [4:0] OP_B      = 5'b00010;
    localparam logic [4:0] OP_BEQZ   = 5'b00100;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW     = 5'b11011;
    localparam logic [4:0] OP_ADDU   = 5'b11100;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [4:0]  op;
    logic        legal;
    logic [7:0]  src2_sel;
    logic [1:0]  src1_sel;

    logic [7:0]  alu_src2;
    logic [1:0]  alu_src1;
    logic        alu_op, mem_rd, mem_wr, pc_write, pc_src, reg_write, wb_src, illegal;

    assign op = ir_q[15:11];

    always_comb begin
        legal    = 1'b1;
        src2_sel = ZERO;
        src1_sel = 2'd0;
        case (op)
            OP_NOP, OP_B, OP_BEQZ: ;
            OP_ADDU:   begin
                src2_sel = RY;
                legal    = (ir_q[1:0] == 2'b01);
            end
            OP_ADDIU:  src2_sel = S_IMM8;
            OP_ADDIU3: src2_sel = S_IMM4;
            OP_LW, OP_SW: src2_sel = S_IMM5;
            OP_LI:     src1_sel = 2'd2;
            default:   legal    = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_src2  = ZERO;
        alu_src1  = 2'd0;
        alu_op    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        wb_src    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_IF: begin
                mem_rd   = 1'b1;
                alu_src1 = 2'd1;
                alu_src2 = ONE;
                if (bus.mem_ready) begin
                    ir_d     = bus.mem_data;
                    pc_write = 1'b1;
                    state_d  = ST_ID;
                end
            end
            ST_ID: begin
                if (op == OP_NOP) begin
                    state_d = ST_IF;
                end else if (!legal) begin
                    illegal = 1'b1;
                    state_d = ST_IF;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                alu_src2 = src2_sel;
                alu_src1 = src1_sel;
                alu_op   = (op == OP_BEQZ);
                case (op)
                    OP_BEQZ: begin
                        pc_write = bus.alu_zero;
                        pc_src   = bus.alu_zero;
                        state_d  = ST_IF;
                    end
                    OP_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        state_d  = ST_IF;
                    end
                    OP_LW, OP_SW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // Operand selects are held so the effective address stays valid during waits
                alu_src2 = src2_sel;
                alu_src1 = src1_sel;
                mem_rd   = (op == OP_LW);
                mem_wr   = (op != OP_LW);
                if (bus.mem_ready) begin
                    state_d = (op == OP_LW) ? ST_WB : ST_IF;
                end
            end
            ST_WB: begin
                alu_src2  = src2_sel;
                alu_src1  = src1_sel;
                reg_write = 1'b1;
                wb_src    = (op == OP_LW);
                state_d   = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
        if (rst) begin
            alu_src2  = ZERO;
            alu_src1  = 2'd0;
            alu_op    = 1'b0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            reg_write = 1'b0;
            wb_src    = 1'b0;
            illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IF;
            ir_q    <= 16'h0800;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.ir        = ir_q;
    assign bus.ALU_Src2  = alu_src2;
    assign bus.alu_src1  = alu_src1;
    assign bus.alu_op    = alu_op;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.pc_write  = pc_write;
    assign bus.pc_src    = pc_src;
    assign bus.reg_write = reg_write;
    assign bus.wb_src    = wb_src;
    assign bus.illegal   = illegal;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle directed check of multicycle_ctrl: a trace table of inputs and expected
// outputs, followed by hand-written reset sequences.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Expected bundle: {ALU_Src2, alu_src1, op,rd,wr,pw,ps,rw,wb,ill, ir}
    typedef struct packed {
        logic [15:0] data;
        logic        rdy;
        logic        z;
        logic [33:0] exp;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    vec_t        tv[$];

    logic [33:0] act;
    assign act = {bus.ALU_Src2, bus.alu_src1, bus.alu_op, bus.mem_rd, bus.mem_wr,
                  bus.pc_write, bus.pc_src, bus.reg_write, bus.wb_src, bus.illegal, bus.ir};

    function automatic vec_t mk(logic [15:0] d, logic r, logic z, logic [7:0] s2,
                                logic [1:0] s1, logic [7:0] f, logic [15:0] irv);
        vec_t v;
        v.data = d;
        v.rdy  = r;
        v.z    = z;
        v.exp  = {s2, s1, f, irv};
        return v;
    endfunction

    task automatic chk(input string name, input logic [33:0] exp);
        total++;
        if (act !== exp || (bus.mem_rd && bus.mem_wr)) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic r, input logic z);
        bus.mem_data  = d;
        bus.mem_ready = r;
        bus.alu_zero  = z;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // flags: op rd wr pw ps rw wb ill
        tv.push_back(mk(16'h0000, 0, 0, 8'h26, 2'd1, 8'b0100_0000, 16'h0800));
        tv.push_back(mk(16'h0000, 0, 0, 8'h26, 2'd1, 8'b0100_0000, 16'h0800));
        tv.push_back(mk(16'h4905, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h0800));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'h4905));
        tv.push_back(mk(16'h0000, 0, 0, 8'h16, 2'd0, 8'b0000_0000, 16'h4905));
        tv.push_back(mk(16'h0000, 0, 0, 8'h16, 2'd0, 8'b0000_0100, 16'h4905));
        tv.push_back(mk(16'hE14D, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h4905));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'hE14D));
        tv.push_back(mk(16'h0000, 0, 0, 8'h06, 2'd0, 8'b0000_0000, 16'hE14D));
        tv.push_back(mk(16'h0000, 0, 0, 8'h06, 2'd0, 8'b0000_0100, 16'hE14D));
        tv.push_back(mk(16'h4143, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'hE14D));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'h4143));
        tv.push_back(mk(16'h0000, 0, 0, 8'h14, 2'd0, 8'b0000_0000, 16'h4143));
        tv.push_back(mk(16'h0000, 0, 0, 8'h14, 2'd0, 8'b0000_0100, 16'h4143));
        tv.push_back(mk(16'h9A64, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h4143));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'h9A64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h15, 2'd0, 8'b0000_0000, 16'h9A64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h15, 2'd0, 8'b0100_0000, 16'h9A64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h15, 2'd0, 8'b0100_0000, 16'h9A64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h15, 2'd0, 8'b0100_0000, 16'h9A64));
        tv.push_back(mk(16'h0000, 1, 0, 8'h15, 2'd0, 8'b0100_0000, 16'h9A64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h15, 2'd0, 8'b0000_0110, 16'h9A64));
        tv.push_back(mk(16'hDA64, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h9A64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'hDA64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h15, 2'd0, 8'b0000_0000, 16'hDA64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h15, 2'd0, 8'b0010_0000, 16'hDA64));
        tv.push_back(mk(16'h0000, 1, 0, 8'h15, 2'd0, 8'b0010_0000, 16'hDA64));
        tv.push_back(mk(16'h2103, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'hDA64));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'h2103));
        tv.push_back(mk(16'h0000, 0, 1, 8'h10, 2'd0, 8'b1001_1000, 16'h2103));
        tv.push_back(mk(16'h2103, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h2103));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'h2103));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b1000_0000, 16'h2103));
        tv.push_back(mk(16'hF800, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h2103));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0001, 16'hF800));
        tv.push_back(mk(16'h0800, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'hF800));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'h0800));
        tv.push_back(mk(16'h1005, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h0800));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'h1005));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0001_1000, 16'h1005));
        tv.push_back(mk(16'h6A07, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h1005));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0000, 16'h6A07));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd2, 8'b0000_0000, 16'h6A07));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd2, 8'b0000_0100, 16'h6A07));
        tv.push_back(mk(16'hE14F, 1, 0, 8'h26, 2'd1, 8'b0101_0000, 16'h6A07));
        tv.push_back(mk(16'h0000, 0, 0, 8'h10, 2'd0, 8'b0000_0001, 16'hE14F));
        tv.push_back(mk(16'h0000, 0, 0, 8'h26, 2'd1, 8'b0100_0000, 16'hE14F));

        // Two reset edges; mem_ready high to show reset gates the fetch strobes
        rst = 1'b1;
        drive(16'h4905, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_hold", {8'h10, 2'd0, 8'b0000_0000, 16'h0800});
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].data, tv[i].rdy, tv[i].z);
            @(negedge clk);
            chk($sformatf("vec%0d", i), tv[i].exp);
            @(posedge clk); #1;
        end

        // LW stalled in MEM, then reset mid-access
        drive(16'h9A64, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("lw_mem_wait", {8'h15, 2'd0, 8'b0100_0000, 16'h9A64});
        @(posedge clk); #1;
        rst = 1'b1;
        drive(16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_mid_mem", {8'h10, 2'd0, 8'b0000_0000, 16'h9A64});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_after_edge", {8'h10, 2'd0, 8'b0000_0000, 16'h0800});
        @(posedge clk); #1;
        rst = 1'b0;
        drive(16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_if", {8'h26, 2'd1, 8'b0100_0000, 16'h0800});
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_if_hold", {8'h26, 2'd1, 8'b0100_0000, 16'h0800});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
